byte_serial_subtractor: RTL and testbench

Multi-cycle 32-bit subtractor computing A - B one 8-bit slice per clock, least-significant slice first. The borrow is chained from each slice into the next. It returns the difference plus unsigned-borrow, signed-overflow and zero flags. It is the inverse-operation companion to the slice-based 32-bit adder and serves datapath users (branch compare, SUB/SLT support) that can tolerate a fixed multi-cycle latency.

---
 rtl/byte_serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_byte_serial_subtractor.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/byte_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: A - B computed one SLICE-bit slice per clock, LSB slice first,
// with the borrow chained between slices. Results and flags update together on entry to DONE.
module byte_serial_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int unsigned      base;
  logic [SLICE-1:0] a_k, b_k;
  logic [SLICE:0]   sub;
  logic [WIDTH-1:0] shadow_upd;

  // One slice of the borrow chain; sub[SLICE] is the slice borrow-out.
  always_comb begin
    base       = SLICE * cnt_q;
    a_k        = a_q[base +: SLICE];
    b_k        = b_q[base +: SLICE];
    sub        = {1'b0, a_k} - {1'b0, b_k} - (SLICE + 1)'(bin_q);
    shadow_upd = shadow_q;
    shadow_upd[base +: SLICE] = sub[SLICE-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    a_d        = a_q;
    b_d        = b_q;
    shadow_d   = shadow_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          bin_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        shadow_d = shadow_upd;
        bin_d    = sub[SLICE];
        if (cnt_q == LastCnt) begin
          state_d    = StDone;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          diff_d     = shadow_upd;
          borrow_d   = sub[SLICE];
          overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (shadow_upd[WIDTH-1] != a_q[WIDTH-1]);
          zero_d     = (shadow_upd == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      shadow_q   <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      shadow_q   <= shadow_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Scoreboard bench for byte_serial_subtractor: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_byte_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b, diff;
  logic        busy, done, borrow, overflow, zero;

  byte_serial_subtractor #(.WIDTH(32), .SLICE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    res_t        r;
  } vec_t;

  res_t        exp_q[$];
  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {29'b0, diff, borrow, overflow, zero}, {29'b0, e});
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input vec_t v, input bit hold);
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    exp_q.push_back(v.r);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a = $urandom;
      b = $urandom;
      check("busy_run", {62'b0, busy, done}, 64'd2);
      check("diff_hold", {32'b0, diff}, {32'b0, last_d});
      @(posedge clk);
    end
    @(negedge clk);
    check("done_latency", {62'b0, busy, done}, 64'd1);
    if (!hold) start = 1'b0;
    last_d = v.r.d;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {27'b0, busy, done, diff, borrow, overflow, zero}, 64'd0);
  endtask

  initial begin
    //            a              b              diff           bo    ov    z
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{32'h0100_0000, 32'h0000_0001, '{32'h00FF_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{32'h0000_0100, 32'h0000_0001, '{32'h0000_00FF, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[8] = '{32'h0000_0000, 32'h8000_0000, '{32'h8000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[9] = '{32'h0001_0000, 32'h0000_FFFF, '{32'h0000_0001, 1'b0, 1'b0, 1'b0}};

    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    last_d = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Isolated operations, each accepted from IDLE.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], 1'b0);
      @(negedge clk);
    end

    // start held high: each new op is accepted in the DONE cycle.
    for (int i = 9; i >= 0; i--) run_op(vecs[i], 1'b1);
    start = 1'b0;
    @(negedge clk);

    // Abort two cycles after accept.
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_before_abort", {63'b0, busy}, 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort_async");
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    last_d = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_done_after_abort", {62'b0, busy, done}, 64'd0);
    end

    run_op(vecs[4], 1'b0);
    @(negedge clk);
    run_op(vecs[3], 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
